// File: rtl/election_pkg.sv
// Shared types and constants for the election house bonus logic.
package election_pkg;

    typedef enum logic [1:0] {
        NONE  = 2'b00,
        TANK1 = 2'b01,
        TANK2 = 2'b10
    } owner_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACTIVE = 2'b01,
        WARN   = 2'b10
    } bonus_state_t;

    localparam int unsigned SOF_PER_SEC = 30;

endpackage

// File: rtl/bonus_timer.sv
// One tank's shield FSM and countdown timer; load beats cancel beats tick.
module bonus_timer
    import election_pkg::*;
#(
    parameter int unsigned LoadCount = 300,
    parameter int unsigned WarnCount = 90
) (
    input  logic clk,
    input  logic resetN,
    input  logic load,
    input  logic cancel,
    input  logic tick,
    output logic shield,
    output logic warn,
    output logic expired
);

    localparam int unsigned TW = $clog2(LoadCount + 1);
    localparam logic [TW-1:0] LoadVal = TW'(LoadCount);
    localparam logic [TW-1:0] WarnVal = TW'(WarnCount);

    bonus_state_t state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;

    // expired flags the cycle whose edge takes the FSM to IDLE, so the owner
    // register clears on the same edge as the shield drops.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        expired = 1'b0;
        if (load) begin
            state_d = ACTIVE;
            timer_d = LoadVal;
        end else if (cancel) begin
            state_d = IDLE;
            timer_d = '0;
        end else if (tick && state_q != IDLE) begin
            if (timer_q <= TW'(1)) begin
                state_d = IDLE;
                timer_d = '0;
                expired = 1'b1;
            end else begin
                timer_d = timer_q - TW'(1);
                if (timer_d <= WarnVal) begin
                    state_d = WARN;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= IDLE;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    assign shield = (state_q != IDLE);
    assign warn   = (state_q == WARN);

endmodule

// File: rtl/election_bonus_manager.sv
// Turns election grants into timed tank shields, score pulses and house display controls.
module election_bonus_manager
    import election_pkg::*;
#(
    parameter int unsigned bonusDuration = 10,
    parameter int unsigned warnDuration  = 3,
    parameter int unsigned sofPerSec     = SOF_PER_SEC,
    parameter int unsigned blinkFrames   = 15
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       start_of_frame,
    input  logic       tank1Bonus,
    input  logic       tank2Bonus,
    input  logic       coolingDown,
    output logic       tank1Shield,
    output logic       tank2Shield,
    output logic       tank1ShieldWarn,
    output logic       tank2ShieldWarn,
    output logic       tank1ScoreInc,
    output logic       tank2ScoreInc,
    output logic [1:0] houseOwner,
    output logic       houseBlink
);

    localparam int unsigned BonusTicks = bonusDuration * sofPerSec;
    localparam int unsigned WarnTicks  = warnDuration * sofPerSec;
    localparam int unsigned BlinkW     = (blinkFrames > 1) ? $clog2(blinkFrames) : 1;
    localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(blinkFrames - 1);

    logic tie, grant1, grant2;
    logic expired1, expired2;

    // A simultaneous request from both tanks is a tie: nobody wins the house.
    assign tie    = tank1Bonus & tank2Bonus;
    assign grant1 = tank1Bonus & ~tank2Bonus;
    assign grant2 = tank2Bonus & ~tank1Bonus;

    bonus_timer #(
        .LoadCount(BonusTicks),
        .WarnCount(WarnTicks)
    ) u_timer1 (
        .clk    (clk),
        .resetN (resetN),
        .load   (grant1),
        .cancel (grant2 | tie),
        .tick   (start_of_frame),
        .shield (tank1Shield),
        .warn   (tank1ShieldWarn),
        .expired(expired1)
    );

    bonus_timer #(
        .LoadCount(BonusTicks),
        .WarnCount(WarnTicks)
    ) u_timer2 (
        .clk    (clk),
        .resetN (resetN),
        .load   (grant2),
        .cancel (grant1 | tie),
        .tick   (start_of_frame),
        .shield (tank2Shield),
        .warn   (tank2ShieldWarn),
        .expired(expired2)
    );

    owner_t owner_q, owner_d;
    logic   score1_q, score2_q;

    always_comb begin
        owner_d = owner_q;
        if (tie) begin
            owner_d = NONE;
        end else if (grant1) begin
            owner_d = TANK1;
        end else if (grant2) begin
            owner_d = TANK2;
        end else if (expired1 && owner_q == TANK1) begin
            owner_d = NONE;
        end else if (expired2 && owner_q == TANK2) begin
            owner_d = NONE;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            owner_q  <= NONE;
            score1_q <= 1'b0;
            score2_q <= 1'b0;
        end else begin
            owner_q  <= owner_d;
            score1_q <= grant1;
            score2_q <= grant2;
        end
    end

    assign houseOwner    = owner_q;
    assign tank1ScoreInc = score1_q;
    assign tank2ScoreInc = score2_q;

    logic              cool_q;
    logic              blink_q, blink_d;
    logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;

    always_comb begin
        blink_d     = blink_q;
        blink_cnt_d = blink_cnt_q;
        if (!coolingDown) begin
            blink_d     = 1'b0;
            blink_cnt_d = '0;
        end else if (!cool_q) begin
            blink_d     = 1'b1;
            blink_cnt_d = '0;
        end else if (start_of_frame) begin
            if (blink_cnt_q >= BlinkLast) begin
                blink_d     = ~blink_q;
                blink_cnt_d = '0;
            end else begin
                blink_cnt_d = blink_cnt_q + BlinkW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cool_q      <= 1'b0;
            blink_q     <= 1'b0;
            blink_cnt_q <= '0;
        end else begin
            cool_q      <= coolingDown;
            blink_q     <= blink_d;
            blink_cnt_q <= blink_cnt_d;
        end
    end

    assign houseBlink = blink_q;

endmodule

// File: tb/tb_election_bonus_manager.sv
// Randomized and directed bench for election_bonus_manager against a tick-count model.
module tb_election_bonus_manager;

    localparam int unsigned SofPerSec = 2;
    localparam int unsigned BonusDur  = 4;
    localparam int unsigned WarnDur   = 1;
    localparam int unsigned BlinkFr   = 3;
    localparam int Full     = BonusDur * SofPerSec;
    localparam int WarnTick = WarnDur * SofPerSec;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       start_of_frame = 1'b0;
    logic       tank1Bonus = 1'b0;
    logic       tank2Bonus = 1'b0;
    logic       coolingDown = 1'b0;
    logic       tank1Shield, tank2Shield, tank1ShieldWarn, tank2ShieldWarn;
    logic       tank1ScoreInc, tank2ScoreInc, houseBlink;
    logic [1:0] houseOwner;

    int checks = 0;
    int fails  = 0;

    // Model state: remaining frame ticks per shield, owner, blink phase.
    int rem1, rem2, owner_m, since_m;
    bit inc1_m, inc2_m, blink_m, prev_cool_m;

    election_bonus_manager #(
        .bonusDuration(BonusDur),
        .warnDuration (WarnDur),
        .sofPerSec    (SofPerSec),
        .blinkFrames  (BlinkFr)
    ) dut (
        .clk            (clk),
        .resetN         (resetN),
        .start_of_frame (start_of_frame),
        .tank1Bonus     (tank1Bonus),
        .tank2Bonus     (tank2Bonus),
        .coolingDown    (coolingDown),
        .tank1Shield    (tank1Shield),
        .tank2Shield    (tank2Shield),
        .tank1ShieldWarn(tank1ShieldWarn),
        .tank2ShieldWarn(tank2ShieldWarn),
        .tank1ScoreInc  (tank1ScoreInc),
        .tank2ScoreInc  (tank2ScoreInc),
        .houseOwner     (houseOwner),
        .houseBlink     (houseBlink)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] observed();
        return {tank1Shield, tank2Shield, tank1ShieldWarn, tank2ShieldWarn,
                tank1ScoreInc, tank2ScoreInc, houseOwner, houseBlink};
    endfunction

    function automatic logic [8:0] expected();
        logic [1:0] own;
        own = 2'(owner_m);
        return {rem1 > 0, rem2 > 0, rem1 > 0 && rem1 <= WarnTick,
                rem2 > 0 && rem2 <= WarnTick, inc1_m, inc2_m, own, blink_m};
    endfunction

    task automatic model_reset();
        rem1 = 0; rem2 = 0; owner_m = 0; since_m = 0;
        inc1_m = 0; inc2_m = 0; blink_m = 0; prev_cool_m = 0;
    endtask

    task automatic model_update(input bit sof, input bit b1, input bit b2, input bit cool);
        inc1_m = 0;
        inc2_m = 0;
        if (b1 && b2) begin
            rem1 = 0; rem2 = 0; owner_m = 0;
        end else if (b1) begin
            rem1 = Full; rem2 = 0; owner_m = 1; inc1_m = 1;
        end else if (b2) begin
            rem2 = Full; rem1 = 0; owner_m = 2; inc2_m = 1;
        end else if (sof) begin
            if (rem1 > 0) begin
                rem1--;
                if (rem1 == 0 && owner_m == 1) owner_m = 0;
            end
            if (rem2 > 0) begin
                rem2--;
                if (rem2 == 0 && owner_m == 2) owner_m = 0;
            end
        end
        if (!cool) begin
            blink_m = 0; since_m = 0;
        end else if (!prev_cool_m) begin
            blink_m = 1; since_m = 0;
        end else if (sof) begin
            since_m++;
            blink_m = ((since_m / BlinkFr) % 2) == 0;
        end
        prev_cool_m = cool;
    endtask

    // Apply inputs for one cycle, advance the model on that edge, sample 1ns after.
    task automatic step(input bit sof, input bit b1, input bit b2, input bit cool);
        start_of_frame = sof;
        tank1Bonus     = b1;
        tank2Bonus     = b2;
        coolingDown    = cool;
        @(posedge clk);
        model_update(sof, b1, b2, cool);
        #1;
        start_of_frame = 0;
        tank1Bonus     = 0;
        tank2Bonus     = 0;
    endtask

    task automatic test_reset();
        resetN = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (observed() !== 9'd0) begin
            $display("FAIL reset: outputs=%b required=%b", observed(), 9'd0);
            fails++;
        end
        resetN = 1;
    endtask

    task automatic test_single_grant();
        int shield_ticks = 0;
        int warn_first = -1;
        int incs = 0;
        step(0, 1, 0, 0);
        checks++;
        if (observed() !== expected()) begin
            $display("FAIL single_grant_t1: got=%b exp=%b", observed(), expected());
            fails++;
        end
        incs += int'(tank1ScoreInc);
        for (int k = 1; k <= 10; k++) begin
            step(1, 0, 0, 0);
            if (tank1Shield) shield_ticks++;
            if (tank1ShieldWarn && warn_first < 0) warn_first = k;
            checks++;
            if (observed() !== expected()) begin
                $display("FAIL single_grant_tick%0d: got=%b exp=%b", k, observed(), expected());
                fails++;
            end
            step(0, 0, 0, 0);
            incs += int'(tank1ScoreInc);
        end
        // Shield stays high after ticks 1..7, drops on tick 8.
        checks++;
        if (shield_ticks != Full - 1 || warn_first != 6 || incs != 1) begin
            $display("FAIL single_grant_shape: high=%0d warn_from=%0d incs=%0d required 7 6 1",
                     shield_ticks, warn_first, incs);
            fails++;
        end
        checks++;
        if (houseOwner !== 2'b00) begin
            $display("FAIL single_grant_owner_expiry: got=%b exp=00", houseOwner);
            fails++;
        end
    endtask

    task automatic test_takeover();
        step(0, 1, 0, 0);
        repeat (3) step(1, 0, 0, 0);
        step(0, 0, 1, 0);
        checks++;
        if ({tank1Shield, tank2Shield, tank2ScoreInc, houseOwner} !== 5'b01110) begin
            $display("FAIL takeover_edge: got=%b exp=01110",
                     {tank1Shield, tank2Shield, tank2ScoreInc, houseOwner});
            fails++;
        end
        for (int k = 1; k <= 9; k++) begin
            step(1, 0, 0, 0);
            checks++;
            if (observed() !== expected()) begin
                $display("FAIL takeover_tick%0d: got=%b exp=%b", k, observed(), expected());
                fails++;
            end
        end
    endtask

    task automatic test_tie();
        step(0, 1, 0, 0);
        step(1, 0, 0, 0);
        step(0, 1, 1, 0);
        checks++;
        if (observed() !== 9'd0 || observed() !== expected()) begin
            $display("FAIL tie: got=%b exp=%b", observed(), 9'd0);
            fails++;
        end
    endtask

    task automatic test_regrant();
        step(0, 0, 1, 0);
        repeat (7) step(1, 0, 0, 0);
        checks++;
        if ({tank2Shield, tank2ShieldWarn} !== 2'b11) begin
            $display("FAIL regrant_warn: got=%b exp=11", {tank2Shield, tank2ShieldWarn});
            fails++;
        end
        // Re-grant lands on a frame tick: the tick must be ignored.
        step(1, 0, 1, 0);
        checks++;
        if ({tank2Shield, tank2ShieldWarn, tank2ScoreInc} !== 3'b101
            || observed() !== expected()) begin
            $display("FAIL regrant_reload: got=%b exp=%b", observed(), expected());
            fails++;
        end
        for (int k = 1; k <= 8; k++) begin
            step(1, 0, 0, 0);
            checks++;
            if (observed() !== expected() || tank2Shield !== (k < 8)) begin
                $display("FAIL regrant_tick%0d: got=%b exp=%b", k, observed(), expected());
                fails++;
            end
        end
    endtask

    task automatic test_blink();
        step(0, 0, 0, 1);
        checks++;
        if (houseBlink !== 1'b1) begin
            $display("FAIL blink_rise: got=%b exp=1", houseBlink);
            fails++;
        end
        for (int k = 1; k <= 12; k++) begin
            step(1, 0, 0, 1);
            step(0, 0, 0, 1);
            checks++;
            if (houseBlink !== (((k / 3) % 2) == 0) || observed() !== expected()) begin
                $display("FAIL blink_tick%0d: got=%b exp=%b", k, houseBlink, ((k / 3) % 2) == 0);
                fails++;
            end
        end
        step(0, 0, 0, 0);
        checks++;
        if (houseBlink !== 1'b0) begin
            $display("FAIL blink_fall: got=%b exp=0", houseBlink);
            fails++;
        end
    endtask

    task automatic test_random();
        bit cool = 0;
        for (int n = 0; n < 600; n++) begin
            bit sof, b1, b2;
            sof = ($urandom_range(2) == 0);
            b1  = ($urandom_range(24) == 0);
            b2  = ($urandom_range(24) == 0);
            if ($urandom_range(29) == 0) cool = ~cool;
            step(sof, b1, b2, cool);
            checks++;
            if (observed() !== expected()) begin
                $display("FAIL random_cycle%0d: got=%b exp=%b", n, observed(), expected());
                fails++;
            end
        end
        step(0, 0, 0, 0);
    endtask

    task automatic test_reset_mid_bonus();
        step(0, 1, 0, 1);
        repeat (2) step(1, 0, 0, 1);
        #2;
        resetN = 0;
        #1;
        model_reset();
        checks++;
        if (observed() !== 9'd0) begin
            $display("FAIL reset_mid_bonus: got=%b exp=%b", observed(), 9'd0);
            fails++;
        end
        coolingDown = 0;
        @(posedge clk);
        #1;
        resetN = 1;
        step(1, 0, 0, 0);
        checks++;
        if (observed() !== expected()) begin
            $display("FAIL reset_release: got=%b exp=%b", observed(), expected());
            fails++;
        end
    endtask

    initial begin
        test_reset();
        test_single_grant();
        test_takeover();
        test_tie();
        test_regrant();
        test_blink();
        test_random();
        test_reset_mid_bonus();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
